// File: rtl/uart_rx_if.sv
// Receiver-side bundle for uart_rx: oversample tick, serial line, word size in;
// received word and status pulses out. slave = receiver, master = driver/consumer.
interface uart_rx_if;
  logic       tick_in;
  logic       rx_in;
  logic [3:0] n_bits;
  logic [7:0] data_out;
  logic       rx_done;
  logic       frame_err;
  logic       parity_err;

  modport slave (
    input  tick_in, rx_in, n_bits,
    output data_out, rx_done, frame_err, parity_err
  );

  modport master (
    output tick_in, rx_in, n_bits,
    input  data_out, rx_done, frame_err, parity_err
  );
endinterface

// File: rtl/uart_rx.sv
// Oversampling UART receiver: LSB-first frames of 5..8 data bits, one stop bit.
// Define PARITY_CHECK_EN to expect and check an even parity bit after the data.
//
// state  | meaning
// IDLE   | waiting for line high (arm), then a falling edge
// START  | confirming start bit at its middle
// DATA   | sampling data bits mid-bit, LSB first
// PARITY | sampling the parity bit (PARITY_CHECK_EN only)
// STOP   | sampling the stop bit, publishing the word
module uart_rx #(
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input logic     clock,
  input logic     reset,
  uart_rx_if.slave bus
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] TC_HALF = CW'(OVERSAMPLE/2 - 1);
  localparam logic [CW-1:0] TC_FULL = CW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t           state, state_nxt;
  logic [SYNC_STAGES-1:0] sync_q;
  logic             rxs;
  logic [CW-1:0]    tick_cnt, tick_nxt;
  logic [2:0]       bit_cnt, bit_nxt;
  logic [7:0]       shreg, shreg_nxt;
  logic [3:0]       n_lat, n_lat_nxt, n_eff;
  logic             armed, armed_nxt;
  logic [7:0]       data_q, data_nxt;
  logic             done_q, done_nxt;
  logic             ferr_q, ferr_nxt;
`ifdef PARITY_CHECK_EN
  logic             par_q, par_nxt;
  logic             perr_q, perr_nxt;
`endif

  // Synchronizer resets to the idle level so reset never looks like a start bit
  always_ff @(posedge clock) begin
    if (reset) sync_q <= '1;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], bus.rx_in};
  end

  assign rxs = sync_q[SYNC_STAGES-1];

  always_comb begin
    if (bus.n_bits < 4'd5)      n_eff = 4'd5;
    else if (bus.n_bits > 4'd8) n_eff = 4'd8;
    else                        n_eff = bus.n_bits;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      n_lat    <= 4'd8;
      armed    <= 1'b0;
      data_q   <= '0;
      done_q   <= 1'b0;
      ferr_q   <= 1'b0;
`ifdef PARITY_CHECK_EN
      par_q    <= 1'b0;
      perr_q   <= 1'b0;
`endif
    end else begin
      state    <= state_nxt;
      tick_cnt <= tick_nxt;
      bit_cnt  <= bit_nxt;
      shreg    <= shreg_nxt;
      n_lat    <= n_lat_nxt;
      armed    <= armed_nxt;
      data_q   <= data_nxt;
      done_q   <= done_nxt;
      ferr_q   <= ferr_nxt;
`ifdef PARITY_CHECK_EN
      par_q    <= par_nxt;
      perr_q   <= perr_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt = state;
    tick_nxt  = tick_cnt;
    bit_nxt   = bit_cnt;
    shreg_nxt = shreg;
    n_lat_nxt = n_lat;
    armed_nxt = armed;
    data_nxt  = data_q;
    done_nxt  = 1'b0;
    ferr_nxt  = 1'b0;
`ifdef PARITY_CHECK_EN
    par_nxt   = par_q;
    perr_nxt  = 1'b0;
`endif
    if (bus.tick_in) begin
      case (state)
        IDLE: begin
          if (rxs) begin
            armed_nxt = 1'b1;
          end else if (armed) begin
            state_nxt = START;
            tick_nxt  = '0;
          end
        end
        START: begin
          if (tick_cnt == TC_HALF) begin
            tick_nxt = '0;
            if (!rxs) begin
              state_nxt = DATA;
              bit_nxt   = '0;
              shreg_nxt = '0;
              n_lat_nxt = n_eff;
            end else begin
              state_nxt = IDLE;
            end
          end else begin
            tick_nxt = tick_cnt + CW'(1);
          end
        end
        DATA: begin
          if (tick_cnt == TC_FULL) begin
            tick_nxt           = '0;
            shreg_nxt[bit_cnt] = rxs;
            bit_nxt            = bit_cnt + 3'd1;
            if ({1'b0, bit_cnt} == n_lat - 4'd1) begin
`ifdef PARITY_CHECK_EN
              state_nxt = PARITY;
`else
              state_nxt = STOP;
`endif
            end
          end else begin
            tick_nxt = tick_cnt + CW'(1);
          end
        end
`ifdef PARITY_CHECK_EN
        PARITY: begin
          if (tick_cnt == TC_FULL) begin
            tick_nxt  = '0;
            par_nxt   = rxs;
            state_nxt = STOP;
          end else begin
            tick_nxt = tick_cnt + CW'(1);
          end
        end
`endif
        STOP: begin
          if (tick_cnt == TC_FULL) begin
            tick_nxt  = '0;
            data_nxt  = shreg;
            state_nxt = IDLE;
            // Unused upper shreg bits are zero, so parity over all 8 equals parity over N
`ifdef PARITY_CHECK_EN
            perr_nxt  = ^{shreg, par_q};
`endif
            if (rxs) begin
              done_nxt = 1'b1;
            end else begin
              ferr_nxt  = 1'b1;
              armed_nxt = 1'b0;
            end
          end else begin
            tick_nxt = tick_cnt + CW'(1);
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign bus.data_out  = data_q;
  assign bus.rx_done   = done_q;
  assign bus.frame_err = ferr_q;
`ifdef PARITY_CHECK_EN
  assign bus.parity_err = perr_q;
`else
  assign bus.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: loopback-style frames, false start, break, word sizes,
// mid-frame reset, and (with PARITY_CHECK_EN) parity checking.
module tb_uart_rx;

  localparam int OS  = 16;
  localparam int DIV = 27;
  localparam int BIT = OS * DIV;
`ifdef PARITY_CHECK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   div_cnt = 0;

  uart_rx_if bus();

  uart_rx #(.OVERSAMPLE(OS), .SYNC_STAGES(2)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (div_cnt == DIV - 1) div_cnt = 0;
    else                    div_cnt = div_cnt + 1;
  end
  assign bus.tick_in = (div_cnt == DIV - 1);

  int   n_done = 0, n_ferr = 0, n_perr = 0, n_perr_done = 0, n_both = 0, n_long = 0;
  logic prev_done = 1'b0, prev_ferr = 1'b0, prev_perr = 1'b0;

  always @(negedge clock) begin
    if (bus.rx_done === 1'b1)    n_done = n_done + 1;
    if (bus.frame_err === 1'b1)  n_ferr = n_ferr + 1;
    if (bus.parity_err === 1'b1) n_perr = n_perr + 1;
    if (bus.parity_err === 1'b1 && bus.rx_done === 1'b1) n_perr_done = n_perr_done + 1;
    if (bus.rx_done === 1'b1 && bus.frame_err === 1'b1)  n_both = n_both + 1;
    if ((bus.rx_done === 1'b1 && prev_done) || (bus.frame_err === 1'b1 && prev_ferr) ||
        (bus.parity_err === 1'b1 && prev_perr))
      n_long = n_long + 1;
    prev_done = (bus.rx_done === 1'b1);
    prev_ferr = (bus.frame_err === 1'b1);
    prev_perr = (bus.parity_err === 1'b1);
  end

  int n_checks = 0, n_fail = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic even_par(input logic [7:0] d, input int nb);
    logic p = 1'b0;
    for (int i = 0; i < nb; i++) p ^= d[i];
    return p;
  endfunction

  task automatic wait_bits(input int nbits);
    repeat (nbits * BIT) @(negedge clock);
  endtask

  task automatic send_frame(input logic [7:0] d, input int nb, input logic par_bit,
                            input logic stop_bit);
    bus.rx_in = 1'b0;
    wait_bits(1);
    for (int i = 0; i < nb; i++) begin
      bus.rx_in = d[i];
      wait_bits(1);
    end
    if (PAR_EN) begin
      bus.rx_in = par_bit;
      wait_bits(1);
    end
    bus.rx_in = stop_bit;
    wait_bits(1);
  endtask

  task automatic idle_bits(input int nbits);
    bus.rx_in = 1'b1;
    wait_bits(nbits);
  endtask

  int d0, f0, p0, pd0;

  initial begin
    bus.rx_in  = 1'b1;
    bus.n_bits = 4'd8;
    reset      = 1'b1;
    repeat (5) @(negedge clock);
    check_val("rst_data",  bus.data_out,   8'h00);
    check_val("rst_done",  bus.rx_done,    1'b0);
    check_val("rst_ferr",  bus.frame_err,  1'b0);
    check_val("rst_perr",  bus.parity_err, 1'b0);
    reset = 1'b0;
    idle_bits(1);

    // 8-bit word 0x75
    d0 = n_done; f0 = n_ferr;
    send_frame(8'h75, 8, even_par(8'h75, 8), 1'b1);
    idle_bits(1);
    check_val("t1_done", n_done - d0, 1);
    check_val("t1_ferr", n_ferr - f0, 0);
    check_val("t1_data", bus.data_out, 8'h75);

    // glitch shorter than half a bit is rejected
    d0 = n_done; f0 = n_ferr;
    bus.rx_in = 1'b0;
    repeat (3 * DIV) @(negedge clock);
    idle_bits(2);
    check_val("t2_done", n_done - d0, 0);
    check_val("t2_ferr", n_ferr - f0, 0);
    check_val("t2_hold", bus.data_out, 8'h75);

    // stop bit low, then break for 5 bit times
    d0 = n_done; f0 = n_ferr;
    send_frame(8'h52, 8, even_par(8'h52, 8), 1'b0);
    wait_bits(5);
    check_val("t3_ferr", n_ferr - f0, 1);
    check_val("t3_done", n_done - d0, 0);
    check_val("t3_data", bus.data_out, 8'h52);
    idle_bits(2);
    check_val("t3_ferr_after", n_ferr - f0, 1);
    check_val("t3_done_after", n_done - d0, 0);

    // 5-bit word 10101
    bus.n_bits = 4'd5;
    d0 = n_done;
    send_frame(8'h15, 5, even_par(8'h15, 5), 1'b1);
    idle_bits(1);
    check_val("t4_done", n_done - d0, 1);
    check_val("t4_data", bus.data_out, 8'h15);

    // n_bits=3 clamps to 5; change to 8 mid-frame must be ignored
    bus.n_bits = 4'd3;
    d0 = n_done; f0 = n_ferr;
    fork
      send_frame(8'h0A, 5, even_par(8'h0A, 5), 1'b1);
      begin
        wait_bits(3);
        bus.n_bits = 4'd8;
      end
    join
    idle_bits(1);
    check_val("clamp5_done", n_done - d0, 1);
    check_val("clamp5_ferr", n_ferr - f0, 0);
    check_val("clamp5_data", bus.data_out, 8'h0A);

    // n_bits=12 clamps to 8
    bus.n_bits = 4'd12;
    d0 = n_done;
    send_frame(8'hC3, 8, even_par(8'hC3, 8), 1'b1);
    idle_bits(1);
    check_val("clamp8_done", n_done - d0, 1);
    check_val("clamp8_data", bus.data_out, 8'hC3);

    // reset in the middle of data bit 3
    bus.n_bits = 4'd8;
    d0 = n_done; f0 = n_ferr;
    bus.rx_in = 1'b0;
    wait_bits(1);
    for (int i = 0; i < 3; i++) begin
      bus.rx_in = (i == 1) ? 1'b0 : 1'b1;
      wait_bits(1);
    end
    bus.rx_in = 1'b0;
    repeat (BIT / 2) @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check_val("t5_rst_data", bus.data_out, 8'h00);
    check_val("t5_rst_done", bus.rx_done,  1'b0);
    idle_bits(2);
    send_frame(8'hA5, 8, even_par(8'hA5, 8), 1'b1);
    idle_bits(1);
    check_val("t5_done", n_done - d0, 1);
    check_val("t5_ferr", n_ferr - f0, 0);
    check_val("t5_data", bus.data_out, 8'hA5);

`ifdef PARITY_CHECK_EN
    // 0x52 has three ones: correct even parity bit is 1
    d0 = n_done; p0 = n_perr; pd0 = n_perr_done;
    send_frame(8'h52, 8, 1'b0, 1'b1);
    idle_bits(1);
    check_val("t6_bad_done", n_done - d0, 1);
    check_val("t6_bad_perr", n_perr - p0, 1);
    check_val("t6_bad_same", n_perr_done - pd0, 1);
    check_val("t6_bad_data", bus.data_out, 8'h52);
    d0 = n_done; p0 = n_perr;
    send_frame(8'h52, 8, 1'b1, 1'b1);
    idle_bits(1);
    check_val("t6_ok_done", n_done - d0, 1);
    check_val("t6_ok_perr", n_perr - p0, 0);
`else
    check_val("perr_tied", n_perr, 0);
`endif

    check_val("done_ferr_excl", n_both, 0);
    check_val("pulse_width",    n_long, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
